// File: rtl/nand_bank_pipe.sv
// nand_bank_pipe: CH independent NIN-input NAND channels behind a LAT-stage
// valid-tagged pipeline, with a saturating counter of output bit toggles.
//
// Optional feature macro: NAND_BANK_FAULT_INJ_EN (adds stuck-at fault ports).
//
// Ports:
//   CLK      in   clock, all state updates on rising edge
//   RST      in   synchronous active-high reset
//   A        in   [CH*NIN] channel c uses A[c*NIN +: NIN]
//   EN       in   sample A this cycle
//   CLR      in   synchronous clear of TOG_CNT / TOG_SAT
//   FLT_MASK in   [CH] (macro only) per-channel fault enable
//   FLT_VAL  in   [CH] (macro only) per-channel forced value
//   Y        out  [CH] registered NAND results
//   Y_VLD    out  Y updated this cycle with a new sample
//   TOG_CNT  out  [CNTW] saturating count of Y bit transitions
//   TOG_SAT  out  sticky, counter reached all-ones
module nand_bank_pipe #(
  parameter int unsigned CH   = 4,
  parameter int unsigned NIN  = 2,
  parameter int unsigned LAT  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CH*NIN-1:0] A,
  input  logic              EN,
  input  logic              CLR,
`ifdef NAND_BANK_FAULT_INJ_EN
  input  logic [CH-1:0]     FLT_MASK,
  input  logic [CH-1:0]     FLT_VAL,
`endif
  output logic [CH-1:0]     Y,
  output logic              Y_VLD,
  output logic [CNTW-1:0]   TOG_CNT,
  output logic              TOG_SAT
);

  localparam int unsigned DW   = $clog2(CH + 1);
  // Sum is CNTW+1 bits; widened only if a single update could exceed that.
  localparam int unsigned SUMW = ((CNTW + 1) > (DW + 1)) ? (CNTW + 1) : (DW + 1);
  localparam logic [SUMW-1:0] CNT_MAX = SUMW'({CNTW{1'b1}});

  logic [CH-1:0]   nand_c;
  logic [CH-1:0]   s1_c;
  logic [CH-1:0]   fin_d_c;
  logic            fin_v_c;
  logic [CH-1:0]   diff_c;
  logic [DW-1:0]   d_c;
  logic [SUMW-1:0] sum_c;
  logic            sat_c;
  logic [CNTW-1:0] cnt_nxt_c;

  // Stage-1 value: per-channel NAND, optionally overridden by fault injection
  always_comb begin
    nand_c = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      nand_c[c] = ~&A[c*NIN +: NIN];
    end
`ifdef NAND_BANK_FAULT_INJ_EN
    s1_c = (nand_c & ~FLT_MASK) | (FLT_VAL & FLT_MASK);
`else
    s1_c = nand_c;
`endif
  end

  // Pipeline ahead of Y; Y itself is the last of the LAT stages
  generate
    if (LAT == 1) begin : g_direct
      assign fin_d_c = s1_c;
      assign fin_v_c = EN;
    end else begin : g_pipe
      logic [CH-1:0] stg_d [LAT-1];
      logic          stg_v [LAT-1];

      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < int'(LAT) - 1; i++) begin
            stg_d[i] <= '0;
            stg_v[i] <= 1'b0;
          end
        end else begin
          stg_d[0] <= s1_c;
          stg_v[0] <= EN;
          for (int i = 1; i < int'(LAT) - 1; i++) begin
            stg_d[i] <= stg_d[i-1];
            stg_v[i] <= stg_v[i-1];
          end
        end
      end

      assign fin_d_c = stg_d[LAT-2];
      assign fin_v_c = stg_v[LAT-2];
    end
  endgenerate

  // Toggle distance between incoming and current Y, and clamped accumulation
  always_comb begin
    diff_c = fin_d_c ^ Y;
    d_c    = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      d_c = d_c + DW'(diff_c[c]);
    end
    sum_c     = SUMW'(TOG_CNT) + SUMW'(d_c);
    sat_c     = (sum_c >= CNT_MAX);
    cnt_nxt_c = sat_c ? CNTW'(CNT_MAX) : CNTW'(sum_c);
  end

  // Output register and counter; CLR discards the count but Y still advances
  always_ff @(posedge CLK) begin
    if (RST) begin
      Y       <= '0;
      Y_VLD   <= 1'b0;
      TOG_CNT <= '0;
      TOG_SAT <= 1'b0;
    end else begin
      Y_VLD <= fin_v_c;
      if (fin_v_c) begin
        Y <= fin_d_c;
      end
      if (CLR) begin
        TOG_CNT <= '0;
        TOG_SAT <= 1'b0;
      end else if (fin_v_c) begin
        TOG_CNT <= cnt_nxt_c;
        if (sat_c) begin
          TOG_SAT <= 1'b1;
        end
      end
    end
  end

endmodule
